// File: rtl/quotient_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : quotient_multiplier
// Brief    : Pipelined shift-add reconstruction of dividend = quotient *
//            divisor + remainder, placed behind the N-bit divider. Each
//            pipeline stage folds in one divisor bit. The block raises
//            overflow when the result does not fit in DIVIDEND bits, and
//            rem_err when the remainder could not have come from a legal
//            division. Both sides use a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module quotient_multiplier #(
  parameter int DIVIDEND = 16,
  parameter int DIVISOR  = 8
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DIVIDEND-1:0] quotient,
  input  logic [DIVISOR-1:0]  divisor,
  input  logic [DIVISOR-1:0]  remainder,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DIVIDEND-1:0] dividend,
  output logic                overflow,
  output logic                rem_err
);

  // Accumulator width is exact: (2^D-1)(2^V-1) + (2^V-1) < 2^(D+V).
  localparam int ACC_W = DIVIDEND + DIVISOR;
  localparam int LAST  = DIVISOR - 1;

  // Per-stage state. Stage k has folded in divisor bits [k:0].
  logic [DIVISOR-1:0]  valid_q, valid_d;
  logic [DIVISOR-1:0]  rerr_q,  rerr_d;
  logic [ACC_W-1:0]    acc_q [DIVISOR];
  logic [ACC_W-1:0]    acc_d [DIVISOR];
  logic [DIVIDEND-1:0] quo_q [DIVISOR];
  logic [DIVIDEND-1:0] quo_d [DIVISOR];
  logic [DIVISOR-1:0]  dvs_q [DIVISOR];
  logic [DIVISOR-1:0]  dvs_d [DIVISOR];

  // A result that is waiting on downstream freezes the whole pipe.
  logic stall;
  assign stall    = valid_q[LAST] && !out_ready;
  assign in_ready = !stall;

  // Next-state for every stage: hold on stall, otherwise shift one stage.
  always_comb begin
    valid_d = valid_q;
    rerr_d  = rerr_q;
    acc_d   = acc_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    if (!stall) begin
      // Entry stage: seed the accumulator with the remainder and bit 0.
      valid_d[0] = in_valid;
      acc_d[0]   = ACC_W'(remainder) + (divisor[0] ? ACC_W'(quotient) : '0);
      quo_d[0]   = quotient;
      dvs_d[0]   = divisor;
      rerr_d[0]  = (remainder >= divisor);
      // Later stages: add the quotient shifted by the stage index when that
      // divisor bit is set.
      for (int k = 1; k < DIVISOR; k++) begin
        valid_d[k] = valid_q[k-1];
        acc_d[k]   = acc_q[k-1]
                   + (dvs_q[k-1][k] ? (ACC_W'(quo_q[k-1]) << k) : '0);
        quo_d[k]   = quo_q[k-1];
        dvs_d[k]   = dvs_q[k-1];
        rerr_d[k]  = rerr_q[k-1];
      end
    end
  end

  // Stage registers; reset discards every in-flight transaction at once.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      rerr_q  <= '0;
      acc_q   <= '{default: '0};
      quo_q   <= '{default: '0};
      dvs_q   <= '{default: '0};
    end else begin
      valid_q <= valid_d;
      rerr_q  <= rerr_d;
      acc_q   <= acc_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
    end
  end

  // Outputs come from the last stage and read as zero while it is empty.
  always_comb begin
    out_valid = valid_q[LAST];
    dividend  = '0;
    overflow  = 1'b0;
    rem_err   = 1'b0;
    if (valid_q[LAST]) begin
      dividend = acc_q[LAST][DIVIDEND-1:0];
      overflow = |acc_q[LAST][ACC_W-1:DIVIDEND];
      rem_err  = rerr_q[LAST];
    end
  end

  // The last stage's operand copies have no consumer.
  logic unused_tail;
  assign unused_tail = ^{quo_q[LAST], dvs_q[LAST]};

endmodule
`default_nettype wire

// File: tb/tb_quotient_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : tb_quotient_multiplier
// Brief    : Directed bench for quotient_multiplier (DIVIDEND=16, DIVISOR=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_quotient_multiplier;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] quotient;
  logic [7:0]  divisor;
  logic [7:0]  remainder;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] dividend;
  logic        overflow;
  logic        rem_err;

  int n_vec = 0;
  int n_err = 0;

  quotient_multiplier #(.DIVIDEND(16), .DIVISOR(8)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .quotient  (quotient),
    .divisor   (divisor),
    .remainder (remainder),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dividend  (dividend),
    .overflow  (overflow),
    .rem_err   (rem_err)
  );

  always #5 clock = ~clock;

  // Drive one operand set into an empty pipe and wait for its result.
  // lat counts clock edges from the accept edge (inclusive) to the result.
  task automatic send_one(input logic [15:0] q, input logic [7:0] d,
                          input logic [7:0] r, output int lat);
    @(negedge clock);
    quotient  = q;
    divisor   = d;
    remainder = r;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clock);
      lat++;
    end
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    quotient  = '0;
    divisor   = '0;
    remainder = '0;
    #1;
    n_vec++;
    if ({out_valid, dividend, overflow, rem_err} !== 19'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h want 0",
               {out_valid, dividend, overflow, rem_err});
    end
    #12 reset_n = 1'b1;
    @(negedge clock);
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_basic();
    int lat;
    send_one(16'd100, 8'd7, 8'd3, lat);
    n_vec++;
    if (lat !== 8) begin
      n_err++;
      $display("FAIL basic_latency: got %0d want 8", lat);
    end
    n_vec++;
    if ({out_valid, dividend, overflow, rem_err} !== {1'b1, 16'd703, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL basic_result: got v=%b d=%0d ov=%b re=%b want v=1 d=703 ov=0 re=0",
               out_valid, dividend, overflow, rem_err);
    end
    @(negedge clock);
    n_vec++;
    if ({out_valid, dividend} !== 17'd0) begin
      n_err++;
      $display("FAIL basic_retire: got v=%b d=%0d want v=0 d=0", out_valid, dividend);
    end
  endtask

  // Overflow, divisor zero, rem_err and width edges.
  task automatic test_vectors();
    logic [15:0] tq [7];
    logic [7:0]  td [7];
    logic [7:0]  tr [7];
    logic [15:0] te [7];
    logic        to [7];
    logic        tre[7];
    int lat;
    tq  = '{16'd65535, 16'd5, 16'd10, 16'd65535, 16'd32768, 16'd0,   16'd0};
    td  = '{8'd255,    8'd0,  8'd3,   8'd1,      8'd2,      8'd255,  8'd0};
    tr  = '{8'd254,    8'd0,  8'd3,   8'd0,      8'd0,      8'd200,  8'd255};
    te  = '{16'hFFFF,  16'd0, 16'd33, 16'hFFFF,  16'd0,     16'd200, 16'd255};
    to  = '{1'b1,      1'b0,  1'b0,   1'b0,      1'b1,      1'b0,    1'b0};
    tre = '{1'b0,      1'b1,  1'b1,   1'b0,      1'b0,      1'b0,    1'b1};
    for (int i = 0; i < 7; i++) begin
      send_one(tq[i], td[i], tr[i], lat);
      n_vec++;
      if ({out_valid, dividend, overflow, rem_err} !== {1'b1, te[i], to[i], tre[i]}) begin
        n_err++;
        $display("FAIL vector_%0d: got v=%b d=%h ov=%b re=%b want v=1 d=%h ov=%b re=%b",
                 i, out_valid, dividend, overflow, rem_err, te[i], to[i], tre[i]);
      end
    end
    @(negedge clock);
  endtask

  task automatic test_back_to_back();
    int sent = 0;
    int got  = 0;
    bit first_seen = 1'b0;
    out_ready = 1'b1;
    fork
      begin
        int guard = 0;
        while (sent < 12 && guard < 200) begin
          @(negedge clock);
          quotient  = 16'(sent);
          divisor   = 8'(sent + 1);
          remainder = 8'd0;
          in_valid  = 1'b1;
          #1;
          if (in_ready) begin
            @(posedge clock);
            sent++;
          end else begin
            @(posedge clock);
          end
          guard++;
        end
        @(negedge clock);
        in_valid = 1'b0;
      end
      begin
        int guard = 0;
        while (got < 12 && guard < 300) begin
          @(negedge clock);
          guard++;
          if (out_valid && !first_seen) begin
            first_seen = 1'b1;
            out_ready  = 1'b0;
            #1;
            n_vec++;
            if (in_ready !== 1'b0) begin
              n_err++;
              $display("FAIL bp_in_ready_drop: got %b want 0", in_ready);
            end
            for (int h = 0; h < 5; h++) begin
              @(negedge clock);
              n_vec++;
              if ({out_valid, in_ready, dividend} !== {1'b1, 1'b0, 16'd0}) begin
                n_err++;
                $display("FAIL bp_hold_%0d: got v=%b rdy=%b d=%0d want v=1 rdy=0 d=0",
                         h, out_valid, in_ready, dividend);
              end
            end
            out_ready = 1'b1;
          end
          if (out_valid && out_ready) begin
            n_vec++;
            if (dividend !== 16'(got * (got + 1))) begin
              n_err++;
              $display("FAIL bp_result_%0d: got %0d want %0d", got, dividend, got * (got + 1));
            end
            got++;
          end
        end
        n_vec++;
        if (got !== 12) begin
          n_err++;
          $display("FAIL bp_count: got %0d want 12", got);
        end
      end
    join
    repeat (10) @(negedge clock);
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL bp_no_extra: got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_async_reset();
    int guard = 0;
    int ghost = 0;
    int lat;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      quotient  = 16'(i + 1);
      divisor   = 8'd3;
      remainder = 8'd0;
      in_valid  = 1'b1;
    end
    @(negedge clock);
    in_valid = 1'b0;
    while (!out_valid && guard < 20) begin
      @(negedge clock);
      guard++;
    end
    n_vec++;
    if ({out_valid, dividend} !== {1'b1, 16'd3}) begin
      n_err++;
      $display("FAIL rst_inflight: got v=%b d=%0d want v=1 d=3", out_valid, dividend);
    end
    #2 reset_n = 1'b0;
    #1;
    n_vec++;
    if ({out_valid, in_ready, dividend} !== {1'b0, 1'b1, 16'd0}) begin
      n_err++;
      $display("FAIL rst_immediate: got v=%b rdy=%b d=%0d want v=0 rdy=1 d=0",
               out_valid, in_ready, dividend);
    end
    @(negedge clock);
    #2 reset_n = 1'b1;
    out_ready = 1'b1;
    repeat (20) begin
      @(negedge clock);
      if (out_valid) ghost++;
    end
    n_vec++;
    if (ghost !== 0) begin
      n_err++;
      $display("FAIL rst_ghosts: got %0d results want 0", ghost);
    end
    send_one(16'd9, 8'd9, 8'd8, lat);
    n_vec++;
    if ({lat, out_valid, dividend} !== {32'd8, 1'b1, 16'd89}) begin
      n_err++;
      $display("FAIL rst_after: got lat=%0d v=%b d=%0d want lat=8 v=1 d=89",
               lat, out_valid, dividend);
    end
    @(negedge clock);
  endtask

  // Divider outputs fed straight back in must rebuild the original dividend.
  task automatic test_loopback();
    int alist [9];
    int dlist [7];
    logic [15:0] va [128];
    logic [15:0] vq [128];
    logic [7:0]  vd [128];
    logic [7:0]  vr [128];
    int nv  = 0;
    int got = 0;
    alist = '{0, 1, 255, 256, 4095, 12345, 32768, 65534, 65535};
    dlist = '{1, 2, 3, 7, 128, 254, 255};
    for (int i = 0; i < 9; i++) begin
      for (int j = 0; j < 7; j++) begin
        va[nv] = 16'(alist[i]);
        vd[nv] = 8'(dlist[j]);
        vq[nv] = 16'(alist[i] / dlist[j]);
        vr[nv] = 8'(alist[i] % dlist[j]);
        nv++;
      end
    end
    for (int i = 0; i < 40; i++) begin
      int a;
      int d;
      a = int'($urandom_range(0, 65535));
      d = int'($urandom_range(1, 255));
      va[nv] = 16'(a);
      vd[nv] = 8'(d);
      vq[nv] = 16'(a / d);
      vr[nv] = 8'(a % d);
      nv++;
    end
    out_ready = 1'b1;
    fork
      begin
        for (int j = 0; j < nv; j++) begin
          @(negedge clock);
          quotient  = vq[j];
          divisor   = vd[j];
          remainder = vr[j];
          in_valid  = 1'b1;
        end
        @(negedge clock);
        in_valid = 1'b0;
      end
      begin
        int guard = 0;
        while (got < nv && guard < 400) begin
          @(negedge clock);
          guard++;
          if (out_valid) begin
            n_vec++;
            if ({dividend, overflow, rem_err} !== {va[got], 2'b00}) begin
              n_err++;
              $display("FAIL loop_%0d: got d=%0d ov=%b re=%b want d=%0d ov=0 re=0 (q=%0d dv=%0d r=%0d)",
                       got, dividend, overflow, rem_err, va[got], vq[got], vd[got], vr[got]);
            end
            got++;
          end
        end
      end
    join
    n_vec++;
    if (got !== nv) begin
      n_err++;
      $display("FAIL loop_count: got %0d want %0d", got, nv);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_back_to_back();
    test_async_reset();
    test_loopback();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
